// File: rtl/frontend_command_definition_pkg.sv
// Shared frontend command types: write-address packing {bank, row, col} and
// the {valid, addr} window entry exposed by the write-address tracker.
package frontend_command_definition_pkg;

   localparam int BANK_BITS = 2;
   localparam int ROW_BITS  = 4;
   localparam int COL_BITS  = 4;
   localparam int WADDR_W   = BANK_BITS + ROW_BITS + COL_BITS;

   typedef struct packed {
      logic [BANK_BITS-1:0] bank;
      logic [ROW_BITS-1:0]  row;
      logic [COL_BITS-1:0]  col;
   } waddr_t;

   typedef struct packed {
      logic   vld;
      waddr_t addr;
   } wentry_t;

   // A one-entry window still needs a one-bit index port.
   function automatic int idx_width(input int window);
      return (window > 1) ? $clog2(window) : 1;
   endfunction

endpackage

// File: rtl/write_addr_tracker_if.sv
// Push/pop/query bus of the write-address tracker; slave is the tracker side,
// master drives the requests and observes status, window and hazard result.
interface write_addr_tracker_if #(
   parameter int ADDR_WIDTH = frontend_command_definition_pkg::WADDR_W,
   parameter int DEPTH_LOG2 = 4,
   parameter int WINDOW     = 8
);
   import frontend_command_definition_pkg::*;

   localparam int IDX_W = idx_width(WINDOW);

   logic                            i_wr_en;
   logic [ADDR_WIDTH-1:0]           i_data;
   logic                            i_rd_en;
   logic                            i_flush;
   logic                            i_query_valid;
   logic [ADDR_WIDTH-1:0]           i_query_addr;
   logic [ADDR_WIDTH:0]             o_head;
   logic [WINDOW*(ADDR_WIDTH+1)-1:0] o_window;
   logic [DEPTH_LOG2:0]             o_count;
   logic                            o_full;
   logic                            o_empty;
   logic                            o_overflow;
   logic                            o_hit;
   logic [IDX_W-1:0]                o_hit_idx;

   modport slave (
      input  i_wr_en, i_data, i_rd_en, i_flush, i_query_valid, i_query_addr,
      output o_head, o_window, o_count, o_full, o_empty, o_overflow, o_hit, o_hit_idx
   );

   modport master (
      output i_wr_en, i_data, i_rd_en, i_flush, i_query_valid, i_query_addr,
      input  o_head, o_window, o_count, o_full, o_empty, o_overflow, o_hit, o_hit_idx
   );

endinterface

// File: rtl/write_addr_tracker_match.sv
// WINDOW-way address compare with youngest-first (highest slice) priority.
// Purely combinational; the parent registers hit and index.
module addr_match_prio #(
   parameter int AW     = 10,
   parameter int WINDOW = 8,
   parameter int IDX_W  = 3
) (
   input  logic [WINDOW-1:0]    i_vld,
   input  logic [WINDOW*AW-1:0] i_addr,
   input  logic [AW-1:0]        i_query,
   output logic                 o_hit,
   output logic [IDX_W-1:0]     o_idx
);

   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      for (int k = 0; k < WINDOW; k++) begin
         if (i_vld[k] && (i_addr[k*AW +: AW] == i_query)) begin
            o_hit = 1'b1;
            o_idx = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/write_addr_tracker.sv
// In-order write-address FIFO exposing its youngest WINDOW slots, with a
// registered read-after-write hazard check (1-cycle latency, no stall).
module write_addr_tracker
   import frontend_command_definition_pkg::*;
#(
   parameter int ADDR_WIDTH = WADDR_W,
   parameter int DEPTH_LOG2 = 4,
   parameter int WINDOW     = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   write_addr_tracker_if.slave  bus
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int EW    = ADDR_WIDTH + 1;
   localparam int IDX_W = idx_width(WINDOW);
   localparam logic [DEPTH_LOG2-1:0] WIN_OFS = DEPTH_LOG2'(WINDOW);

   generate
      if (WINDOW < 1 || WINDOW > DEPTH) begin : g_bad_window
         $error("write_addr_tracker: WINDOW must lie in 1..2**DEPTH_LOG2");
      end
   endgenerate

   logic [ADDR_WIDTH-1:0]   r_mem [DEPTH];
   logic [DEPTH-1:0]        r_vld;
   logic [PW-1:0]           r_wr_ptr;
   logic [PW-1:0]           r_rd_ptr;
   logic                    r_full;
   logic                    r_empty;
   logic                    r_overflow;
   logic                    r_hit;
   logic [IDX_W-1:0]        r_hit_idx;

   logic                    w_rd_req;
   logic                    w_wr_req;
   logic                    w_wr_fire;
   logic [DEPTH_LOG2-1:0]   w_wr_slot;
   logic [DEPTH_LOG2-1:0]   w_rd_slot;
   logic [PW-1:0]           w_wr_ptr_nxt;
   logic [PW-1:0]           w_rd_ptr_nxt;
   logic [DEPTH-1:0]        w_vld_nxt;
   logic [WINDOW*EW-1:0]    w_window;
   logic [WINDOW-1:0]       w_cmp_vld;
   logic [WINDOW*ADDR_WIDTH-1:0] w_cmp_addr;
   logic                    w_match_hit;
   logic [IDX_W-1:0]        w_match_idx;

   assign w_rd_req  = bus.i_rd_en & ~r_empty;
   assign w_wr_req  = bus.i_wr_en & (~r_full | w_rd_req);
   assign w_wr_fire = w_wr_req & ~bus.i_flush;
   assign w_wr_slot = r_wr_ptr[DEPTH_LOG2-1:0];
   assign w_rd_slot = r_rd_ptr[DEPTH_LOG2-1:0];

   // Pop clears before push sets, so a push/pop on the same (full) slot keeps it valid.
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_vld_nxt    = r_vld;
      if (bus.i_flush) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         w_vld_nxt    = '0;
      end else begin
         if (w_rd_req) begin
            w_vld_nxt[w_rd_slot] = 1'b0;
            w_rd_ptr_nxt         = r_rd_ptr + PW'(1);
         end
         if (w_wr_req) begin
            w_vld_nxt[w_wr_slot] = 1'b1;
            w_wr_ptr_nxt         = r_wr_ptr + PW'(1);
         end
      end
   end

   // Visible window from current state; compare window from post-edge state.
   always_comb begin
      logic [DEPTH_LOG2-1:0] cur_slot;
      logic [DEPTH_LOG2-1:0] nxt_slot;
      cur_slot   = '0;
      nxt_slot   = '0;
      w_window   = '0;
      w_cmp_vld  = '0;
      w_cmp_addr = '0;
      for (int k = 0; k < WINDOW; k++) begin
         cur_slot = r_wr_ptr[DEPTH_LOG2-1:0] - WIN_OFS + DEPTH_LOG2'(k);
         nxt_slot = w_wr_ptr_nxt[DEPTH_LOG2-1:0] - WIN_OFS + DEPTH_LOG2'(k);
         w_window[k*EW +: EW] = r_vld[cur_slot] ? {1'b1, r_mem[cur_slot]} : '0;
         w_cmp_vld[k] = w_vld_nxt[nxt_slot];
         w_cmp_addr[k*ADDR_WIDTH +: ADDR_WIDTH] =
            (w_wr_fire && (nxt_slot == w_wr_slot)) ? bus.i_data : r_mem[nxt_slot];
      end
   end

   addr_match_prio #(
      .AW     (ADDR_WIDTH),
      .WINDOW (WINDOW),
      .IDX_W  (IDX_W)
   ) u_match (
      .i_vld   (w_cmp_vld),
      .i_addr  (w_cmp_addr),
      .i_query (bus.i_query_addr),
      .o_hit   (w_match_hit),
      .o_idx   (w_match_idx)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_vld      <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
         r_hit      <= 1'b0;
         r_hit_idx  <= '0;
      end else begin
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_vld      <= w_vld_nxt;
         r_full     <= (w_wr_ptr_nxt[PW-1] != w_rd_ptr_nxt[PW-1]) &&
                       (w_wr_ptr_nxt[DEPTH_LOG2-1:0] == w_rd_ptr_nxt[DEPTH_LOG2-1:0]);
         r_empty    <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
         r_overflow <= ~bus.i_flush &
                       (r_overflow | (bus.i_wr_en & r_full & ~w_rd_req));
         r_hit      <= bus.i_query_valid & w_match_hit;
         r_hit_idx  <= (bus.i_query_valid & w_match_hit) ? w_match_idx : '0;
      end
   end

   // Payload storage needs no reset: every read is qualified by its valid bit.
   always_ff @(posedge i_clk) begin
      if (w_wr_fire) begin
         r_mem[w_wr_slot] <= bus.i_data;
      end
   end

   assign bus.o_head     = r_vld[w_rd_slot] ? {1'b1, r_mem[w_rd_slot]} : '0;
   assign bus.o_window   = w_window;
   assign bus.o_count    = r_wr_ptr - r_rd_ptr;
   assign bus.o_full     = r_full;
   assign bus.o_empty    = r_empty;
   assign bus.o_overflow = r_overflow;
   assign bus.o_hit      = r_hit;
   assign bus.o_hit_idx  = r_hit_idx;

endmodule

// File: tb/tb_write_addr_tracker.sv
// Directed self-checking bench for write_addr_tracker (16 deep, window 8, 10-bit addresses).
module tb_write_addr_tracker;
   import frontend_command_definition_pkg::*;

   localparam int AW = WADDR_W;
   localparam int EW = AW + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   write_addr_tracker_if #(.ADDR_WIDTH(AW), .DEPTH_LOG2(4), .WINDOW(8)) bus ();

   write_addr_tracker #(.ADDR_WIDTH(AW), .DEPTH_LOG2(4), .WINDOW(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   function automatic logic [EW-1:0] ent(input logic [AW-1:0] a);
      wentry_t e;
      e.vld  = 1'b1;
      e.addr = waddr_t'(a);
      return e;
   endfunction

   function automatic logic [EW-1:0] slice(input int k);
      return bus.o_window[k*EW +: EW];
   endfunction

   task automatic idle();
      bus.i_wr_en = 1'b0; bus.i_data = '0; bus.i_rd_en = 1'b0;
      bus.i_flush = 1'b0; bus.i_query_valid = 1'b0; bus.i_query_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] d);
      bus.i_wr_en = 1'b1; bus.i_data = d;
      step();
      bus.i_wr_en = 1'b0;
   endtask

   task automatic flush();
      bus.i_flush = 1'b1;
      step();
      bus.i_flush = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      #2 rst_n = 1'b0;
      #20;
      n_checks++; if (bus.o_empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", bus.o_empty); else n_pass++;
      n_checks++; if (bus.o_full !== 1'b0) $display("FAIL rst_full: got %b want 0", bus.o_full); else n_pass++;
      n_checks++; if (bus.o_count !== 5'd0) $display("FAIL rst_count: got %0d want 0", bus.o_count); else n_pass++;
      n_checks++; if (bus.o_overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", bus.o_overflow); else n_pass++;
      n_checks++; if ({bus.o_hit, bus.o_hit_idx} !== 4'd0) $display("FAIL rst_hit: got %b/%0d want 0/0", bus.o_hit, bus.o_hit_idx); else n_pass++;
      n_checks++; if (bus.o_head !== '0) $display("FAIL rst_head: got %h want 0", bus.o_head); else n_pass++;
      n_checks++; if (bus.o_window !== '0) $display("FAIL rst_window: got %h want 0", bus.o_window); else n_pass++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic_push();
      push(10'h011); push(10'h022); push(10'h033);
      n_checks++; if (bus.o_count !== 5'd3) $display("FAIL basic_count: got %0d want 3", bus.o_count); else n_pass++;
      n_checks++; if (bus.o_head !== ent(10'h011)) $display("FAIL basic_head: got %h want %h", bus.o_head, ent(10'h011)); else n_pass++;
      n_checks++; if (slice(5) !== ent(10'h011)) $display("FAIL basic_s5: got %h want %h", slice(5), ent(10'h011)); else n_pass++;
      n_checks++; if (slice(6) !== ent(10'h022)) $display("FAIL basic_s6: got %h want %h", slice(6), ent(10'h022)); else n_pass++;
      n_checks++; if (slice(7) !== ent(10'h033)) $display("FAIL basic_s7: got %h want %h", slice(7), ent(10'h033)); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (slice(k) !== '0) $display("FAIL basic_s%0d_invalid: got %h want 0", k, slice(k)); else n_pass++;
      end
      n_checks++; if (bus.o_empty !== 1'b0) $display("FAIL basic_empty: got %b want 0", bus.o_empty); else n_pass++;
   endtask

   task automatic test_full_push_pop();
      flush();
      for (int i = 0; i < 16; i++) push(AW'(10'h100 + i));
      n_checks++; if (bus.o_full !== 1'b1) $display("FAIL fill_full: got %b want 1", bus.o_full); else n_pass++;
      n_checks++; if (bus.o_count !== 5'd16) $display("FAIL fill_count: got %0d want 16", bus.o_count); else n_pass++;
      bus.i_wr_en = 1'b1; bus.i_rd_en = 1'b1; bus.i_data = 10'h0AA;
      step();
      idle();
      n_checks++; if (bus.o_full !== 1'b1) $display("FAIL pp_full: got %b want 1", bus.o_full); else n_pass++;
      n_checks++; if (bus.o_count !== 5'd16) $display("FAIL pp_count: got %0d want 16", bus.o_count); else n_pass++;
      n_checks++; if (bus.o_head !== ent(10'h101)) $display("FAIL pp_head: got %h want %h", bus.o_head, ent(10'h101)); else n_pass++;
      n_checks++; if (slice(7) !== ent(10'h0AA)) $display("FAIL pp_s7: got %h want %h", slice(7), ent(10'h0AA)); else n_pass++;
      n_checks++; if (slice(6) !== ent(10'h10F)) $display("FAIL pp_s6: got %h want %h", slice(6), ent(10'h10F)); else n_pass++;
      n_checks++; if (bus.o_overflow !== 1'b0) $display("FAIL pp_ovf: got %b want 0", bus.o_overflow); else n_pass++;
   endtask

   task automatic test_overflow_flush();
      push(10'h0BB);
      n_checks++; if (bus.o_overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", bus.o_overflow); else n_pass++;
      n_checks++; if (bus.o_count !== 5'd16) $display("FAIL ovf_count: got %0d want 16", bus.o_count); else n_pass++;
      n_checks++; if (slice(7) !== ent(10'h0AA)) $display("FAIL ovf_s7: got %h want %h", slice(7), ent(10'h0AA)); else n_pass++;
      step();
      n_checks++; if (bus.o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.o_overflow); else n_pass++;
      // flush with a push while still full: push dropped, no new overflow
      bus.i_flush = 1'b1; bus.i_wr_en = 1'b1; bus.i_data = 10'h0BB;
      step();
      idle();
      n_checks++; if (bus.o_overflow !== 1'b0) $display("FAIL fl_ovf: got %b want 0", bus.o_overflow); else n_pass++;
      n_checks++; if (bus.o_empty !== 1'b1) $display("FAIL fl_empty: got %b want 1", bus.o_empty); else n_pass++;
      n_checks++; if (bus.o_count !== 5'd0) $display("FAIL fl_count: got %0d want 0", bus.o_count); else n_pass++;
      n_checks++; if (bus.o_full !== 1'b0) $display("FAIL fl_full: got %b want 0", bus.o_full); else n_pass++;
      n_checks++; if (bus.o_window !== '0) $display("FAIL fl_window: got %h want 0", bus.o_window); else n_pass++;
   endtask

   task automatic test_query();
      bus.i_wr_en = 1'b1; bus.i_data = 10'h040;
      bus.i_query_valid = 1'b1; bus.i_query_addr = 10'h040;
      step();
      idle();
      n_checks++; if ({bus.o_hit, bus.o_hit_idx} !== {1'b1, 3'd7}) $display("FAIL q_same_cycle: got %b/%0d want 1/7", bus.o_hit, bus.o_hit_idx); else n_pass++;
      push(10'h041);
      n_checks++; if ({bus.o_hit, bus.o_hit_idx} !== 4'd0) $display("FAIL q_novalid: got %b/%0d want 0/0", bus.o_hit, bus.o_hit_idx); else n_pass++;
      push(10'h040);
      bus.i_query_valid = 1'b1; bus.i_query_addr = 10'h040;
      step();
      n_checks++; if ({bus.o_hit, bus.o_hit_idx} !== {1'b1, 3'd7}) $display("FAIL q_youngest: got %b/%0d want 1/7", bus.o_hit, bus.o_hit_idx); else n_pass++;
      bus.i_query_addr = 10'h041;
      step();
      n_checks++; if ({bus.o_hit, bus.o_hit_idx} !== {1'b1, 3'd6}) $display("FAIL q_041: got %b/%0d want 1/6", bus.o_hit, bus.o_hit_idx); else n_pass++;
      bus.i_query_addr = 10'h099;
      step();
      n_checks++; if ({bus.o_hit, bus.o_hit_idx} !== 4'd0) $display("FAIL q_miss: got %b/%0d want 0/0", bus.o_hit, bus.o_hit_idx); else n_pass++;
      bus.i_query_addr = 10'h040; bus.i_flush = 1'b1;
      step();
      idle();
      n_checks++; if ({bus.o_hit, bus.o_hit_idx} !== 4'd0) $display("FAIL q_flush: got %b/%0d want 0/0", bus.o_hit, bus.o_hit_idx); else n_pass++;
   endtask

   task automatic test_pop_query();
      push(10'h050);
      bus.i_rd_en = 1'b1; bus.i_query_valid = 1'b1; bus.i_query_addr = 10'h050;
      step();
      idle();
      n_checks++; if (bus.o_hit !== 1'b0) $display("FAIL pq_hit: got %b want 0", bus.o_hit); else n_pass++;
      n_checks++; if (bus.o_empty !== 1'b1) $display("FAIL pq_empty: got %b want 1", bus.o_empty); else n_pass++;
      bus.i_rd_en = 1'b1;
      step();
      idle();
      n_checks++; if (bus.o_count !== 5'd0) $display("FAIL pop_empty_count: got %0d want 0", bus.o_count); else n_pass++;
      n_checks++; if (bus.o_head !== '0) $display("FAIL pop_empty_head: got %h want 0", bus.o_head); else n_pass++;
   endtask

   task automatic test_back_to_back_wrap_reset();
      logic [AW-1:0] q[$];
      logic [EW-1:0] exp_head;
      bit do_rd, do_wr, wr, rd;
      for (int i = 0; i < 40; i++) begin
         wr = (i % 7) != 6;
         rd = (i >= 4) && ((i % 5) != 0);
         bus.i_wr_en = wr; bus.i_rd_en = rd; bus.i_data = AW'(10'h200 + i);
         do_rd = rd && (q.size() > 0);
         do_wr = wr && ((q.size() < 16) || do_rd);
         if (do_rd) void'(q.pop_front());
         if (do_wr) q.push_back(AW'(10'h200 + i));
         step();
         exp_head = (q.size() > 0) ? ent(q[0]) : '0;
         n_checks++; if (bus.o_head !== exp_head) $display("FAIL wrap_head[%0d]: got %h want %h", i, bus.o_head, exp_head); else n_pass++;
         n_checks++; if (bus.o_count !== 5'(q.size())) $display("FAIL wrap_count[%0d]: got %0d want %0d", i, bus.o_count, q.size()); else n_pass++;
      end
      bus.i_wr_en = 1'b1; bus.i_rd_en = 1'b1; bus.i_data = 10'h3FF;
      bus.i_query_valid = 1'b1; bus.i_query_addr = 10'h3FF;
      step();
      n_checks++; if (bus.o_hit !== 1'b1) $display("FAIL pre_rst_hit: got %b want 1", bus.o_hit); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.o_count !== 5'd0) $display("FAIL arst_count: got %0d want 0", bus.o_count); else n_pass++;
      n_checks++; if (bus.o_empty !== 1'b1) $display("FAIL arst_empty: got %b want 1", bus.o_empty); else n_pass++;
      n_checks++; if (bus.o_head !== '0) $display("FAIL arst_head: got %h want 0", bus.o_head); else n_pass++;
      n_checks++; if (bus.o_window !== '0) $display("FAIL arst_window: got %h want 0", bus.o_window); else n_pass++;
      n_checks++; if ({bus.o_hit, bus.o_hit_idx} !== 4'd0) $display("FAIL arst_hit: got %b/%0d want 0/0", bus.o_hit, bus.o_hit_idx); else n_pass++;
      n_checks++; if ({bus.o_full, bus.o_overflow} !== 2'b00) $display("FAIL arst_flags: got %b want 00", {bus.o_full, bus.o_overflow}); else n_pass++;
      idle();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      idle();
      test_reset();
      test_basic_push();
      test_full_push_pop();
      test_overflow_flush();
      test_query();
      test_pop_query();
      test_back_to_back_wrap_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/write_addr_tracker.md
# write_addr_tracker

Parametrised write-address FIFO with a built-in read-after-write hazard check. Sits between the frontend command decoder and the bank scheduler. Buffers accepted write addresses in order and exposes the youngest `WINDOW` entries with valid bits. Compares a query (read) address against that window each cycle and returns a registered hit flag and hit index. Also adds flush, fill count, sticky overflow, and a defined simultaneous push/pop on full.

## Interface
- `ADDR_WIDTH`, default `ROW_BITS+COL_BITS+BANK_BITS` (from the shared define file): address width; packing is {bank, row, col}.
- `DEPTH_LOG2`, default 4: storage depth is 2**DEPTH_LOG2 entries.
- `WINDOW`, default 8: number of youngest slots exposed and compared. Must satisfy 1 ≤ WINDOW ≤ 2**DEPTH_LOG2; an elaboration-time assertion enforces this.
- `IDX_W`, derived, not overridable: max(1, $clog2(WINDOW)).

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_wr_en`  in  1  push request.
- `i_data`  in  ADDR_WIDTH  address to push.
- `i_rd_en`  in  1  pop request (retires the oldest entry).
- `i_flush`  in  1  synchronous clear of all contents.
- `i_query_valid`  in  1  a hazard query is present this cycle.
- `i_query_addr`  in  ADDR_WIDTH  address to check.
- `o_head`  out  ADDR_WIDTH+1  oldest entry as {valid, addr}; valid=0 when empty.
- `o_window`  out  WINDOW*(ADDR_WIDTH+1)  youngest slots as {valid, addr}. Slice k=0 is the oldest of the window; slice WINDOW-1 is the most recently written slot.
- `o_count`  out  DEPTH_LOG2+1  number of occupied entries.
- `o_full`, `o_empty`  out  1 each  registered status flags.
- `o_overflow`  out  1  sticky; set by a dropped push.
- `o_hit`  out  1  registered query match.
- `o_hit_idx`  out  IDX_W  window slice of the youngest match; 0 when `o_hit`=0.

## Operation
- Pointers are DEPTH_LOG2+1 bits, with the extra MSB used for wrap detection.
  - empty when wr_ptr==rd_ptr.
  - full when the pointers are equal in the low bits and differ in the MSB.
- Push acceptance: `wr_req = i_wr_en & (!o_full | rd_req)`, so push and pop on a full FIFO both succeed. Pop acceptance: `rd_req = i_rd_en & !o_empty`; pop on empty is ignored.
- On push, the slot is written with {1, i_data}. On pop, the slot's valid bit is cleared.
  - Same-cycle push and pop on a full FIFO target the same slot. The push wins: the slot ends valid with the new data.
  - Otherwise push and pop target different slots and both take effect.
- Window slice k reads slot (wr_ptr − WINDOW + k) mod 2**DEPTH_LOG2. Retired or never-written slots show valid=0.
- Flush takes priority over push and pop in the same cycle.
  - Pointers go to 0, all valid bits clear, `o_overflow` clears.
  - The flush-cycle push is dropped and does not set `o_overflow`.
- Overflow: `o_overflow` sets when `i_wr_en` & `o_full` & !`rd_req` & !`i_flush`. It holds until flush or reset.
- Query: a slice matches when its valid bit is set and its address equals `i_query_addr`, evaluated on the post-edge contents. Post-edge contents include this cycle's accepted push and exclude this cycle's pop; a flush leaves nothing to match.
  - `o_hit_idx` is the highest matching k.
  - With `i_query_valid`=0, `o_hit` is 0 next cycle.

## Timing
- Reset values: pointers 0, all valid bits 0, `o_empty`=1, `o_full`=0, `o_count`=0, `o_overflow`=0, `o_hit`=0, `o_hit_idx`=0, `o_head`=0, `o_window` all 0.
- Reset asserted mid-operation discards all contents immediately.
- Push at edge t is visible on `o_head`, `o_window`, `o_count` and the flags from t+1. Pop behaves the same way.
- Query presented in cycle t: result on `o_hit`/`o_hit_idx` from t+1 for one cycle (1-cycle latency, no stall).
- Throughput: one push and one pop per cycle; back-to-back queries every cycle.

## Structure
- Shared package `frontend_command_definition_pkg` holds:
  - the address-packing typedef `waddr_t` {bank, row, col};
  - the window-entry typedef {valid, waddr_t}.
- One sub-module, `addr_match_prio`: WINDOW-way equality compare plus a youngest-first priority encoder producing hit and index. It is combinational; the registering happens in the parent.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 with no pops:
  - `o_count`=3 and `o_head`={1,0x11};
  - window slices 5,6,7 = 0x11, 0x22, 0x33 valid; slices 0–4 invalid.
- Fill all 16 entries, then assert push and pop together with data 0xAA:
  - `o_full` stays 1 and `o_count` stays 16;
  - `o_head` advances to the second entry; 0xAA appears in slice 7.
- With the FIFO full, push 0xBB with no pop:
  - push dropped, `o_overflow`=1 from next cycle;
  - flush clears `o_overflow`, `o_empty`=1, `o_count`=0.
- Push 0x40 at cycle t with a query of 0x40 in the same cycle: `o_hit`=1, `o_hit_idx`=7 at t+1. Push 0x40, 0x41, 0x40, then query 0x40: `o_hit_idx`=7 (youngest match, not 5).
- Pop the only entry 0x50 while querying 0x50 in the same cycle: `o_hit`=0 next cycle. Flush while querying a resident address: `o_hit`=0.
- Run 40 pushes/pops to force pointer wrap, checking `o_head` order against a scoreboard model. Assert `i_rst_n` low mid-stream: every output returns to its reset value without waiting for a clock edge.
